// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, tracking
// outstanding owners in order and dropping fetch responses stale after a flush.
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        instr_flush_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        protocol_err_o
);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                     state;
  logic                       lock_data;
  logic [SW-1:0]              starve_cnt;
  logic [MAX_OUTSTANDING-1:0] owner_q, disc_q;
  logic [PW-1:0]              rd_ptr, wr_ptr;
  logic [CW-1:0]              cnt;
  logic empty, full, pop, push, block, locked_hold, pick_instr, sel_instr, sel_data;

  assign empty = cnt == '0;
  assign full  = cnt == CW'(MAX_OUTSTANDING);
  assign pop   = mem_rvalid_i & ~empty;
  assign block = full & ~pop;

  // A starved fetch overrides the default data-first priority.
  assign pick_instr  = instr_req_i & (~data_req_i | starve_cnt == SW'(STARVE_LIMIT));
  assign locked_hold = state == LOCKED & (lock_data ? data_req_i : instr_req_i);
  assign sel_data    = locked_hold ? lock_data : data_req_i & ~pick_instr;
  assign sel_instr   = locked_hold ? ~lock_data : pick_instr;

  assign mem_req_o   = rstn & (sel_data | sel_instr) & ~block;
  assign push        = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = push & sel_instr;
  assign data_gnt_o  = push & sel_data;
  assign mem_we_o    = sel_data & data_we_i;
  assign mem_be_o    = sel_data ? data_be_i : 4'hf;
  assign mem_addr_o  = sel_data ? data_addr_i : instr_addr_i;
  assign mem_wdata_o = sel_data ? data_wdata_i : '0;

  // A flush in the same cycle also kills the fetch response being popped.
  assign data_rvalid_o  = pop & owner_q[rd_ptr];
  assign instr_rvalid_o = pop & ~owner_q[rd_ptr] & ~disc_q[rd_ptr] & ~instr_flush_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      lock_data      <= 1'b0;
      starve_cnt     <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      state          <= (mem_req_o & ~mem_gnt_i) ? LOCKED : IDLE;
      lock_data      <= sel_data;
      starve_cnt     <= (~instr_req_i | instr_gnt_o) ? '0 : starve_cnt + SW'(starve_cnt != SW'(STARVE_LIMIT));
      protocol_err_o <= protocol_err_o | (mem_rvalid_i & empty);
    end
  end

  // Discard bits of free slots may go stale; a push always rewrites them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_q <= '0;
      disc_q  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
    end else begin
      if (instr_flush_i) disc_q <= disc_q | ~owner_q;
      if (push) begin
        owner_q[wr_ptr] <= sel_data;
        disc_q[wr_ptr]  <= 1'b0;
        wr_ptr          <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, round-robin scoreboard and hand-written
// sequences for blocking, flush, lock, protocol error and reset.
module tb_mem_port_arbiter;
  logic clk = 1'b0, rstn = 1'b0;
  logic instr_req_i = 0, instr_flush_i = 0, data_req_i = 0, data_we_i = 0;
  logic mem_gnt_i = 0, mem_rvalid_i = 0, mem_err_i = 0;
  logic [31:0] instr_addr_i = 32'h100, data_addr_i = 32'h40, data_wdata_i = 32'hdead;
  logic [31:0] mem_rdata_i = '0;
  logic [3:0]  data_be_i = 4'h3;
  logic instr_gnt_o, instr_rvalid_o, instr_err_o, data_gnt_o, data_rvalid_o, data_err_o;
  logic mem_req_o, mem_we_o, protocol_err_o;
  logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;

  int total = 0, passed = 0;

  mem_port_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rstn(rstn),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .instr_flush_i(instr_flush_i),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic ir, dr, we, gnt, e_req, e_ig, e_dg, e_we;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
  } vec_t;

  typedef struct {
    logic owner;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  exp_t e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic ir, input logic dr, input logic we, input logic gnt,
                       input logic rv, input logic fl, input logic [31:0] rdata);
    @(negedge clk);
    instr_req_i = ir; data_req_i = dr; data_we_i = we; mem_gnt_i = gnt;
    mem_rvalid_i = rv; instr_flush_i = fl; mem_rdata_i = rdata; mem_err_i = rdata[0];
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    instr_req_i = 0; data_req_i = 0; data_we_i = 0; mem_gnt_i = 0;
    mem_rvalid_i = 0; instr_flush_i = 0; mem_rdata_i = '0; mem_err_i = 0;
    instr_addr_i = 32'h100; data_addr_i = 32'h40;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    vecs[0] = '{0,0,0,1, 0,0,0,0, 32'h100, 32'h0,    4'hf};
    vecs[1] = '{1,0,0,1, 1,1,0,0, 32'h100, 32'h0,    4'hf};
    vecs[2] = '{0,1,1,1, 1,0,1,1, 32'h40,  32'hdead, 4'h3};
    vecs[3] = '{1,1,0,1, 1,0,1,0, 32'h40,  32'hdead, 4'h3};
    vecs[4] = '{1,1,1,0, 1,0,0,1, 32'h40,  32'hdead, 4'h3};
    vecs[5] = '{1,0,1,0, 1,0,0,0, 32'h100, 32'h0,    4'hf};

    do_reset();
    check("reset_protocol_err", protocol_err_o, 0);
    check("reset_req", mem_req_o, 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      drive(vecs[i].ir, vecs[i].dr, vecs[i].we, vecs[i].gnt, 0, 0, 0);
      check($sformatf("vec%0d_req", i), mem_req_o, vecs[i].e_req);
      check($sformatf("vec%0d_gnt", i), {instr_gnt_o, data_gnt_o}, {vecs[i].e_ig, vecs[i].e_dg});
      if (vecs[i].e_req) begin
        check($sformatf("vec%0d_addr", i), mem_addr_o, vecs[i].e_addr);
        check($sformatf("vec%0d_be", i), mem_be_o, vecs[i].e_be);
        check($sformatf("vec%0d_we", i), mem_we_o, vecs[i].e_we);
        check($sformatf("vec%0d_wdata", i), mem_wdata_o, vecs[i].e_wd);
      end
    end

    // Both requesting, memory always grants, response one cycle later.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 0, 1, k > 0, 0, 32'hC0DE0000 + k - 1);
      check($sformatf("rr%0d_gnt", k), {instr_gnt_o, data_gnt_o}, (k % 5 == 4) ? 2'b10 : 2'b01);
      if (k > 0) begin
        e = sb.pop_front();
        check($sformatf("rr%0d_rvalid", k), {instr_rvalid_o, data_rvalid_o}, e.owner ? 2'b01 : 2'b10);
        check($sformatf("rr%0d_rdata", k), e.owner ? data_rdata_o : instr_rdata_o, e.data);
        check($sformatf("rr%0d_err", k), e.owner ? data_err_o : instr_err_o, {31'b0, e.data[0]});
      end
      sb.push_back('{k % 5 != 4, 32'hC0DE0000 + k});
    end
    drive(0, 0, 0, 0, 1, 0, 32'hC0DE0000 + 19);
    e = sb.pop_front();
    check("rr_last_rvalid", {instr_rvalid_o, data_rvalid_o}, e.owner ? 2'b01 : 2'b10);
    check("rr_sb_empty", sb.size(), 0);

    // Full blocking and push-with-pop while full.
    do_reset();
    drive(0, 1, 0, 1, 0, 0, 0);
    check("full_g0", data_gnt_o, 1);
    drive(0, 1, 0, 1, 0, 0, 0);
    check("full_g1", data_gnt_o, 1);
    drive(0, 1, 0, 1, 0, 0, 0);
    check("full_block", {mem_req_o, data_gnt_o}, 2'b00);
    drive(0, 1, 0, 1, 1, 0, 32'h11);
    check("full_pushpop", {mem_req_o, data_gnt_o, data_rvalid_o}, 3'b111);
    drive(0, 1, 0, 1, 0, 0, 0);
    check("full_still", mem_req_o, 0);
    drive(0, 0, 0, 0, 1, 0, 32'h22);
    check("full_drain0", data_rvalid_o, 1);
    drive(0, 0, 0, 0, 1, 0, 32'h33);
    check("full_drain1", data_rvalid_o, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("full_no_perr", protocol_err_o, 0);

    // Flush with a redirected fetch granted in the flush cycle.
    do_reset();
    drive(1, 0, 0, 1, 0, 0, 0);
    check("fl_g100", instr_gnt_o, 1);
    instr_addr_i = 32'h104;
    drive(1, 0, 0, 1, 0, 0, 0);
    check("fl_g104", instr_gnt_o, 1);
    instr_addr_i = 32'h200;
    drive(1, 0, 0, 1, 1, 1, 32'hA100);
    check("fl_g200", {instr_gnt_o, instr_rvalid_o}, 2'b10);
    check("fl_addr", mem_addr_o, 32'h200);
    drive(0, 0, 0, 0, 1, 0, 32'hA104);
    check("fl_drop104", instr_rvalid_o, 0);
    drive(0, 0, 0, 0, 1, 0, 32'hA200);
    check("fl_r200", {instr_rvalid_o, data_rvalid_o}, 2'b10);
    check("fl_rdata", instr_rdata_o, 32'hA200);

    // Lock on an ungranted data request, then lock drop and instr lock.
    do_reset();
    instr_addr_i = 32'h100;
    drive(0, 1, 0, 0, 0, 0, 0);
    check("lk_c0", {mem_req_o, mem_addr_o[15:0]}, {1'b1, 16'h40});
    drive(1, 1, 0, 0, 0, 0, 0);
    check("lk_c1", {mem_req_o, mem_addr_o[15:0]}, {1'b1, 16'h40});
    drive(1, 1, 0, 0, 0, 0, 0);
    check("lk_c2", mem_addr_o, 32'h40);
    drive(1, 1, 0, 1, 0, 0, 0);
    check("lk_gnt", {instr_gnt_o, data_gnt_o, mem_addr_o[15:0]}, {2'b01, 16'h40});
    drive(1, 0, 0, 1, 0, 0, 0);
    check("lk_instr", {instr_gnt_o, data_gnt_o, mem_addr_o[15:0]}, {2'b10, 16'h100});
    drive(0, 0, 0, 0, 1, 0, 32'h5);
    check("lk_rsp0", {instr_rvalid_o, data_rvalid_o}, 2'b01);
    drive(0, 0, 0, 0, 1, 0, 32'h6);
    check("lk_rsp1", {instr_rvalid_o, data_rvalid_o}, 2'b10);
    drive(0, 1, 0, 0, 0, 0, 0);
    check("lk_d", mem_addr_o, 32'h40);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("lk_drop", {mem_req_o, mem_addr_o[15:0]}, {1'b1, 16'h100});
    drive(1, 1, 0, 0, 0, 0, 0);
    check("lk_ihold", {data_gnt_o, mem_addr_o[15:0]}, {1'b0, 16'h100});

    // Response with nothing outstanding.
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 32'h77);
    check("pe_norv", {instr_rvalid_o, data_rvalid_o}, 2'b00);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("pe_set", protocol_err_o, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("pe_sticky", protocol_err_o, 1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("pe_clear", protocol_err_o, 0);

    // Reset with two outstanding transactions.
    do_reset();
    drive(0, 1, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0, 0);
    check("rs_g1", data_gnt_o, 1);
    @(negedge clk);
    rstn = 1'b0; instr_req_i = 1; mem_rvalid_i = 1;
    #1;
    check("rs_outs", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o}, 5'b0);
    @(negedge clk);
    rstn = 1'b1; instr_req_i = 0; data_req_i = 0; mem_rvalid_i = 0; mem_gnt_i = 0;
    drive(0, 0, 0, 0, 1, 0, 32'h9);
    check("rs_stale_rv", {instr_rvalid_o, data_rvalid_o}, 2'b00);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rs_perr", protocol_err_o, 1);
    drive(0, 1, 0, 1, 0, 0, 0);
    check("rs_q0", data_gnt_o, 1);
    drive(0, 1, 0, 1, 0, 0, 0);
    check("rs_q1", data_gnt_o, 1);
    drive(0, 1, 0, 1, 0, 0, 0);
    check("rs_q2_block", mem_req_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single core memory port between the instruction-fetch interface and the load/store interface. Each side uses req/gnt/rvalid handshakes. The block arbitrates requests and tracks outstanding transactions in an in-order owner queue. It routes each response back to its originator and discards instruction responses made stale by a fetch flush (branch or trap redirect). It sits between the fetch and memory stages and the external instruction/data memory.

## Interface
- MAX_OUTSTANDING, 2: depth of the owner queue; maximum granted-but-unanswered transactions.
- STARVE_LIMIT, 4: consecutive cycles an instruction request may lose arbitration before it gets priority.
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch address
- instr_gnt_o  out  1  fetch request accepted
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch response data
- instr_err_o  out  1  fetch response error
- instr_flush_i  in  1  discard all outstanding fetch responses
- data_req_i  in  1  load/store request
- data_we_i  in  1  1 = store
- data_be_i  in  4  byte enables
- data_addr_i  in  32  load/store address
- data_wdata_i  in  32  store data
- data_gnt_o  out  1  load/store accepted
- data_rvalid_o  out  1  load/store response valid
- data_rdata_o  out  32  load data
- data_err_o  out  1  load/store error
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  4  memory byte enables (4'b1111 for fetch)
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data (0 for fetch)
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid (in order)
- mem_rdata_i  in  32  memory response data
- mem_err_i  in  1  memory response error
- protocol_err_o  out  1  sticky: response arrived with empty owner queue

## Operation
- Owner queue: FIFO of MAX_OUTSTANDING entries {owner (0 = instr, 1 = data), discard}.
  - Push on mem_req_o & mem_gnt_i.
  - Pop on mem_rvalid_i.
- Full blocking: when the queue is full and no pop occurs this cycle, mem_req_o = 0 and both gnt outputs = 0. Push and pop in the same cycle while full is allowed; the count is unchanged.
- Arbitration states: IDLE and LOCKED.
  - In IDLE, the winner is data when data_req_i = 1, otherwise instr.
  - Exception: when starve_cnt == STARVE_LIMIT and instr_req_i = 1, instr wins.
- Lock: if mem_req_o = 1 and mem_gnt_i = 0, the selection is registered and the FSM enters LOCKED.
  - In LOCKED, mem_* stays driven from the locked requester regardless of the other request.
  - LOCKED returns to IDLE on mem_gnt_i.
  - LOCKED also returns to IDLE if the locked requester drops req; mem_req_o then follows the new IDLE selection in the same cycle.
- starve_cnt (saturating at STARVE_LIMIT):
  - increments on each cycle with instr_req_i = 1 and instr not granted;
  - clears on an instr grant or when instr_req_i = 0.
- Grant routing: instr_gnt_o = mem_gnt_i & mem_req_o & sel_instr; data_gnt_o likewise with sel_data. The mem_* fields come from the selected requester.
- Response routing: on mem_rvalid_i, the head entry selects the destination.
  - owner = data: data_rvalid_o = 1.
  - owner = instr and discard = 0: instr_rvalid_o = 1.
  - owner = instr and discard = 1: response dropped, no rvalid.
  - rdata_o and err_o on both sides are mem_rdata_i and mem_err_i unconditionally.
- Flush: instr_flush_i sets discard on every valid instr entry, including an entry popped in the same cycle, whose response is dropped. An instr grant in the flush cycle is pushed with discard = 0, since it is the redirected fetch. Data entries are never discarded.
- mem_rvalid_i with an empty queue: ignored, and protocol_err_o is set until reset.

## Timing
- Reset values:
  - queue empty, FSM IDLE, starve_cnt = 0, protocol_err_o = 0;
  - all gnt and rvalid outputs 0 while rstn is low.
- Request, grant and response paths are combinational passthrough; the block adds zero cycles of latency.
- The queue count updates at the clock edge after the handshake. The earliest response accepted is the cycle after the grant.
- Reset mid-transaction clears the queue; responses arriving after release are counted as protocol errors.

## Test plan
- Both req high every cycle, memory gnt=1, rvalid 1 cycle later, STARVE_LIMIT=4 -> grants go data×4, then instr×1, repeating; every response is routed to its owner.
- MAX_OUTSTANDING=2, gnt=1, rvalid held off -> two grants accepted, then mem_req_o=0 until rvalid; push with simultaneous pop when full -> grant accepted.
- Instr granted at A=0x100, then A=0x104; instr_flush_i pulsed before responses; new grant at 0x200 in the flush cycle -> only the 0x200 response produces instr_rvalid_o.
- Data request with gnt=0 for 3 cycles while instr_req_i rises -> mem_addr_o stays at the data address until gnt; the instr grant follows.
- mem_rvalid_i with empty queue -> no rvalid out; protocol_err_o=1 until rstn low.
- Assert rstn low with 2 outstanding -> all outputs 0; queue empty after release.
